// File: rtl/hex_message_scroller.sv
// Multi-message hex display driver for the six DE10-Lite seven-segment digits.
// Modes: static select, auto-cycle, scroll, freeze. Optional macro DEBOUNCE_EN adds key debounce.
module hex_message_scroller #(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned TICK_HZ         = 2,
   parameter int unsigned NUM_MSG         = 2,
   parameter int unsigned MSG_DIGITS      = 6,
   parameter logic [NUM_MSG*MSG_DIGITS*4-1:0] MSG_INIT = 48'h071030_008150,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       MAX10_CLK1_50,
   input  logic       RESET_N,
   input  logic       KEY_NEXT,
   input  logic [1:0] MODE,
   output logic [7:0] HEX0,
   output logic [7:0] HEX1,
   output logic [7:0] HEX2,
   output logic [7:0] HEX3,
   output logic [7:0] HEX4,
   output logic [7:0] HEX5,
   output logic [9:0] LEDR
);

   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned CNT_W    = $clog2(TICK_DIV);
   localparam int unsigned OFF_W    = $clog2(MSG_DIGITS);

   typedef enum logic [1:0] {
      ModeStatic = 2'b00,
      ModeAuto   = 2'b01,
      ModeScroll = 2'b10,
      ModeFreeze = 2'b11
   } mode_e;

   if (NUM_MSG < 1 || NUM_MSG > 8 || MSG_DIGITS < 6 || TICK_DIV < 2 || DEBOUNCE_CYCLES < 1)
   begin : g_param_check
      $error("hex_message_scroller: illegal parameter value");
   end

   logic key_s1_q, key_s2_q;
   logic press_raw;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         key_s1_q <= 1'b1;
         key_s2_q <= 1'b1;
      end else begin
         key_s1_q <= KEY_NEXT;
         key_s2_q <= key_s1_q;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   // Count consecutive low samples; saturate so a long hold fires only once.
   always_comb begin
      db_cnt_d = db_cnt_q;
      if (key_s2_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
      press_raw = !key_s2_q && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_d;
      end
   end
`else
   logic key_s3_q;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         key_s3_q <= 1'b1;
      end else begin
         key_s3_q <= key_s2_q;
      end
   end

   assign press_raw = key_s3_q && !key_s2_q;
`endif

   mode_e            mode;
   logic [1:0]       mode_q;
   logic [2:0]       idx_q, idx_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             freeze, mode_chg, press, tick, advance;

   assign mode = mode_e'(MODE);

   // Entering freeze is not treated as a mode change so that it retains its state.
   always_comb begin
      freeze   = (mode == ModeFreeze);
      mode_chg = (MODE != mode_q) && !freeze;
      press    = press_raw && !freeze;
      tick     = !freeze && !mode_chg && (cnt_q == CNT_W'(TICK_DIV - 1));
      advance  = press || (tick && (mode == ModeAuto));

      cnt_d = cnt_q;
      idx_d = idx_q;
      off_d = off_q;

      if (!freeze) begin
         if (press || mode_chg || tick) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (advance) begin
         idx_d = (idx_q == 3'(NUM_MSG - 1)) ? 3'd0 : idx_q + 3'd1;
      end

      if ((mode == ModeStatic) || (mode == ModeAuto) || press || mode_chg) begin
         off_d = '0;
      end else if (tick && (mode == ModeScroll)) begin
         off_d = (off_q == OFF_W'(MSG_DIGITS - 1)) ? '0 : off_q + 1'b1;
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         mode_q <= 2'b00;
         idx_q  <= 3'd0;
         off_q  <= '0;
         cnt_q  <= '0;
      end else begin
         mode_q <= MODE;
         idx_q  <= idx_d;
         off_q  <= off_d;
         cnt_q  <= cnt_d;
      end
   end

   function automatic logic [7:0] hex_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // seg_d[0] drives HEX5 (leftmost), seg_d[5] drives HEX0.
   logic [7:0] seg_d [6];
   logic [7:0] hex_q [6];
   logic [9:0] ledr_q;

   always_comb begin
      for (int unsigned p = 0; p < 6; p++) begin
         int unsigned pos;
         int unsigned bit_idx;
         pos = 32'(off_q) + p;
         if (pos >= MSG_DIGITS) begin
            pos = pos - MSG_DIGITS;
         end
         bit_idx  = (32'(idx_q) * MSG_DIGITS + pos) * 4;
         seg_d[p] = hex_seg(MSG_INIT[bit_idx +: 4]);
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         hex_q  <= '{default: 8'hFF};
         ledr_q <= '0;
      end else begin
         hex_q  <= seg_d;
         ledr_q <= {MODE, 8'(8'd1 << idx_q)};
      end
   end

   assign HEX5 = hex_q[0];
   assign HEX4 = hex_q[1];
   assign HEX3 = hex_q[2];
   assign HEX2 = hex_q[3];
   assign HEX1 = hex_q[4];
   assign HEX0 = hex_q[5];
   assign LEDR = ledr_q;

endmodule

// File: tb/tb_hex_message_scroller.sv
// Directed bench for hex_message_scroller at CLK_HZ=10, TICK_HZ=1 (tick every 10 cycles).
module tb_hex_message_scroller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key;
   logic [1:0] mode;
   logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic [9:0] ledr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hex_message_scroller #(
      .CLK_HZ         (10),
      .TICK_HZ        (1),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .MAX10_CLK1_50(clk),
      .RESET_N      (rst_n),
      .KEY_NEXT     (key),
      .MODE         (mode),
      .HEX0         (hex0),
      .HEX1         (hex1),
      .HEX2         (hex2),
      .HEX3         (hex3),
      .HEX4         (hex4),
      .HEX5         (hex5),
      .LEDR         (ledr)
   );

   // Display images packed as {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}.
   localparam logic [47:0] BLANK = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] M0O0  = 48'hC0_92_F9_80_C0_C0;
   localparam logic [47:0] M0O1  = 48'h92_F9_80_C0_C0_C0;
   localparam logic [47:0] M0O2  = 48'hF9_80_C0_C0_C0_92;
   localparam logic [47:0] M0O3  = 48'h80_C0_C0_C0_92_F9;
   localparam logic [47:0] M0O5  = 48'hC0_C0_92_F9_80_C0;
   localparam logic [47:0] M1O0  = 48'hC0_B0_C0_F9_F8_C0;

   typedef struct {
      logic        rst_n;
      logic [1:0]  mode;
      logic        key;
      int          n;
      logic [47:0] hex;
      logic [9:0]  ledr;
   } vec_t;

   vec_t vecs [14];

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [47:0] exp_hex,
                        input logic [9:0] exp_ledr);
      logic [47:0] got;
      got = {hex5, hex4, hex3, hex2, hex1, hex0};
      checks++;
      if (got !== exp_hex || ledr !== exp_ledr) begin
         errors++;
         $display("FAIL %s: got hex=%h ledr=%h, expected hex=%h ledr=%h",
                  name, got, ledr, exp_hex, exp_ledr);
      end
   endtask

   initial begin
      // Reset, static-mode press with wrap, then scroll through a full offset cycle.
      vecs[0]  = '{1'b0, 2'b00, 1'b1, 3,  BLANK, 10'h000};
      vecs[1]  = '{1'b1, 2'b00, 1'b1, 1,  M0O0,  10'h001};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 3,  M0O0,  10'h001};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 1,  M1O0,  10'h002};
      vecs[4]  = '{1'b1, 2'b00, 1'b0, 1,  M1O0,  10'h002};
      vecs[5]  = '{1'b1, 2'b00, 1'b1, 4,  M1O0,  10'h002};
      vecs[6]  = '{1'b1, 2'b00, 1'b0, 3,  M1O0,  10'h002};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 1,  M0O0,  10'h001};
      vecs[8]  = '{1'b1, 2'b00, 1'b1, 4,  M0O0,  10'h001};
      vecs[9]  = '{1'b1, 2'b10, 1'b1, 1,  M0O0,  10'h201};
      vecs[10] = '{1'b1, 2'b10, 1'b1, 30, M0O2,  10'h201};
      vecs[11] = '{1'b1, 2'b10, 1'b1, 1,  M0O3,  10'h201};
      vecs[12] = '{1'b1, 2'b10, 1'b1, 20, M0O5,  10'h201};
      vecs[13] = '{1'b1, 2'b10, 1'b1, 10, M0O0,  10'h201};

      rst_n = 1'b0;
      mode  = 2'b00;
      key   = 1'b1;

      for (int i = 0; i < 14; i++) begin
         rst_n = vecs[i].rst_n;
         mode  = vecs[i].mode;
         key   = vecs[i].key;
         step(vecs[i].n);
         check($sformatf("vec%0d", i), vecs[i].hex, vecs[i].ledr);
      end

      // Freeze mid-scroll at offset 2: press and waiting change nothing.
      step(20);
      check("scroll_off2", M0O2, 10'h201);
      mode = 2'b11;
      step(1);
      check("freeze_enter", M0O2, 10'h301);
      key = 1'b0;
      step(5);
      key = 1'b1;
      step(30);
      check("freeze_hold", M0O2, 10'h301);
      mode = 2'b10;
      step(1);
      check("unfreeze_edge", M0O2, 10'h201);
      step(1);
      check("unfreeze_off0", M0O0, 10'h201);

      // Auto-cycle: press lands on the same edge as the first tick.
      mode = 2'b01;
      step(8);
      key = 1'b0;
      step(2);
      check("auto_pre_tick", M0O0, 10'h101);
      step(1);
      check("auto_coincide_edge", M0O0, 10'h101);
      key = 1'b1;
      step(1);
      check("auto_single_adv", M1O0, 10'h102);
      step(9);
      check("auto_before_next", M1O0, 10'h102);
      step(1);
      check("auto_next_tick", M0O0, 10'h101);

      // Reset in the middle of a scroll.
      mode = 2'b10;
      step(15);
      check("scroll_off1", M0O1, 10'h201);
      rst_n = 1'b0;
      step(1);
      check("midreset_blank", BLANK, 10'h000);
      rst_n = 1'b1;
      step(10);
      check("postreset_off0", M0O0, 10'h201);
      step(2);
      check("postreset_tick", M0O1, 10'h201);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_message_scroller.md
Name: hex_message_scroller

Overview:
Parametrised successor to the two-message HEX birthday selector. Stores NUM_MSG messages of MSG_DIGITS hex digits each and drives the six DE10-Lite seven-segment displays. Four modes: static select by button, auto-cycle, horizontal scroll and freeze. Sits between board I/O (KEY/SW) and HEX0–HEX5/LEDR in the lab top level.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 2, advance/scroll rate in Hz; tick period TICK_DIV = CLK_HZ/TICK_HZ cycles, TICK_DIV >= 2
NUM_MSG, 2, number of stored messages, legal range 1..8
MSG_DIGITS, 6, digits per message, >= 6
MSG_INIT, 48'h071030_008150, packed messages; digit k of message m at bits [(m*MSG_DIGITS+k)*4 +: 4]; default encodes 051800 and 030170
DEBOUNCE_CYCLES, 500000, stable-low cycles required for a press (used only with DEBOUNCE_EN)

Ports:
MAX10_CLK1_50  input  1  system clock; all logic on its rising edge
RESET_N  input  1  synchronous, active-low reset
KEY_NEXT  input  1  raw pushbutton, active-low, asynchronous to clock
MODE  input  2  00 static, 01 auto-cycle, 10 scroll, 11 freeze
HEX0..HEX5  output  8 each  active-low segments; bit0=a..bit6=g, bit7=DP
LEDR  output  10  [7:0] one-hot current message index, [9:8] registered MODE

Behaviour:
- Reset: RESET_N sampled low at a clock edge clears msg_idx, offset and tick counter to 0, and clears the synchroniser and edge flops to 1 (released). Outputs go to HEX* = 8'hFF and LEDR = 0. Reset mid-operation aborts any scroll or debounce in progress.
- First edge with RESET_N high: outputs show message 0, offset 0. All outputs are registered; an internal state change appears on the outputs one cycle later.
- KEY_NEXT: 2-FF synchroniser, then falling-edge detect. A press is a single-cycle pulse, 3 cycles after the input goes low. Holding the key produces exactly one press.
- Tick: counter counts 0..TICK_DIV-1 and pulses tick on the wrap. It free-runs in every mode except freeze, where it holds. It restarts at 0 on any accepted press and on any MODE change.
- msg_idx: on press in modes 00/01/10, msg_idx = (msg_idx+1) mod NUM_MSG. In mode 01, tick also advances msg_idx. A press and a tick in the same cycle advance by exactly one. Press is ignored in mode 11.
- offset: range 0..MSG_DIGITS-1. In mode 10, each tick sets offset = (offset+1) mod MSG_DIGITS. Offset clears to 0 on press, on MODE change, and in modes 00/01.
- Display window: HEX5 shows digit (offset+0) mod MSG_DIGITS of the current message, down to HEX0 showing digit (offset+5) mod MSG_DIGITS. Wrap-around is seamless.
- Decode: full hex 0–F, active-low. Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex). DP bit is always 1 (off).
- LEDR[7:0]: bit msg_idx is set, all other bits clear. LEDR[9:8] = MODE delayed one cycle.
- MODE change: takes effect on the next edge. Freeze retains msg_idx, offset and the tick count.
- NUM_MSG=1: press and tick leave msg_idx at 0 but still restart the tick counter and clear offset.

Optional Feature:
Macro DEBOUNCE_EN.
- Defined: the synchronised key must stay low for DEBOUNCE_CYCLES consecutive cycles before a single press is accepted. Any high sample restarts the count. The press pulse fires once per qualified low period, and the count resets on RESET_N.
- Undefined: there is no debounce counter. The press is the raw synchronised falling edge and DEBOUNCE_CYCLES is unused.

Test Plan:
(Run with CLK_HZ=10, TICK_HZ=1, i.e. TICK_DIV=10, default messages, DEBOUNCE_EN undefined unless stated.)
1. RESET_N low for 3 cycles, then high, MODE=00 -> HEX* = FF during reset; next cycle HEX5..HEX0 = C0,92,F9,80,C0,C0 and LEDR = 10'h001.
2. MODE=00, pulse KEY_NEXT low for 5 cycles -> 4 cycles after the low edge HEX5..HEX0 = C0,B0,C0,F9,F8,C0 and LEDR = 10'h002; a second press returns to message 0 (index wraps).
3. MODE=10, message 0, wait 3 ticks -> HEX5..HEX0 = 80,C0,C0,C0,92,F9 (offset 3, wrapped); after 6 ticks total, offset is back to 0.
4. MODE=01, press asserted in the same cycle as a tick -> msg_idx advances by exactly 1 and the next advance comes 10 cycles later.
5. MODE=11 mid-scroll at offset 2, press plus 30 cycles -> display and LEDR unchanged; switch to MODE=10 -> offset 0, LEDR[9:8] = 10.
6. DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4: low glitches of 3 cycles produce no advance; a 4-cycle low produces exactly one advance; RESET_N pulled low mid-count produces no press.
